// File: rtl/nes_save_pkg.sv
// Shared types for the save-memory arbiter: FSM state encoding and timeout counter width.
package nes_save_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EEP_ACC,
        EEP_HOLD,
        HOST_ACC
    } arb_state_t;

    localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/eeprom_ram_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the last-grant bit favours the requester not served most recently.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last1;

    always_comb begin
        gnt0 = enable && req0 && (!req1 || last1);
        gnt1 = enable && req1 && (!req0 || !last1);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last1 <= 1'b1;
        end else if (gnt0) begin
            last1 <= 1'b0;
        end else if (gnt1) begin
            last1 <= 1'b1;
        end
    end

endmodule

// File: rtl/eeprom_ram_arbiter.sv
// Shares one byte-wide save-memory port between the EEPROM emulator handshake and the host save bridge,
// with hold-until-release done, dirty tracking and ack-timeout recovery.
module eeprom_ram_arbiter
    import nes_save_pkg::*;
#(
    parameter int                MEM_AW    = 21,
    parameter logic [MEM_AW-1:0] ADDR_BASE = '0,
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eep_read,
    input  logic              eep_write,
    input  logic [7:0]        eep_addr,
    input  logic [7:0]        eep_wdata,
    output logic [7:0]        eep_rdata,
    output logic              eep_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [7:0]        host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    input  logic              dirty_clr,
    output logic              dirty,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    arb_state_t           state, state_nxt;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 eep_req, in_acc, tmo, done_now;
    logic                 gnt_eep, gnt_host;
    logic [7:0]           rd_val;

    assign eep_req  = eep_read || eep_write;
    assign in_acc   = (state == EEP_ACC) || (state == HOST_ACC);
    assign tmo      = in_acc && !mem_ack && (cnt == TIMEOUT_W'(TIMEOUT - 1));
    assign done_now = in_acc && (mem_ack || tmo);
    assign rd_val   = mem_ack ? mem_rdata : 8'hFF;

    // host_req is still high during the host_ack cycle; masking it stops a duplicate grant.
    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .enable (state == IDLE),
        .req0   (eep_req),
        .req1   (host_req && !host_ack),
        .gnt0   (gnt_eep),
        .gnt1   (gnt_host)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_eep)       state_nxt = EEP_ACC;
                else if (gnt_host) state_nxt = HOST_ACC;
            end
            EEP_ACC:  if (done_now) state_nxt = EEP_HOLD;
            HOST_ACC: if (done_now) state_nxt = IDLE;
            EEP_HOLD: if (!eep_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // mem_req and eep_done decode the state so a reset drops them without waiting for an edge.
    always_comb begin
        mem_req  = in_acc;
        eep_done = (state == EEP_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            host_rdata  <= 8'h00;
            eep_rdata   <= 8'hFF;
            host_ack    <= 1'b0;
            dirty       <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            host_ack <= 1'b0;
            if (gnt_eep) begin
                mem_we    <= eep_write;
                mem_addr  <= ADDR_BASE + MEM_AW'(eep_addr);
                mem_wdata <= eep_wdata;
                cnt       <= '0;
            end else if (gnt_host) begin
                mem_we    <= host_we;
                mem_addr  <= ADDR_BASE + MEM_AW'(host_addr);
                mem_wdata <= host_wdata;
                cnt       <= '0;
            end else if (in_acc) begin
                cnt <= cnt + 1'b1;
            end

            if (done_now) begin
                if (tmo) timeout_err <= 1'b1;
                if (state == HOST_ACC) begin
                    host_rdata <= rd_val;
                    host_ack   <= 1'b1;
                end else if (!mem_we) begin
                    eep_rdata <= rd_val;
                end
            end

            // A completing EEPROM write beats a coincident clear.
            if (done_now && (state == EEP_ACC) && mem_we) dirty <= 1'b1;
            else if (dirty_clr)                           dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eeprom_ram_arbiter.sv
// Self-checking bench: directed vector table, arbitration/timeout/reset sequences, then random traffic
// checked against a transaction-level model of the save image.
module tb_eeprom_ram_arbiter;

    localparam int                MEM_AW    = 21;
    localparam logic [MEM_AW-1:0] ADDR_BASE = 21'h01000;
    localparam int                TIMEOUT   = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              eep_read = 0, eep_write = 0;
    logic [7:0]        eep_addr = 0, eep_wdata = 0;
    logic [7:0]        eep_rdata;
    logic              eep_done;
    logic              host_req = 0, host_we = 0;
    logic [7:0]        host_addr = 0, host_wdata = 0;
    logic [7:0]        host_rdata;
    logic              host_ack;
    logic              dirty_clr = 0;
    logic              dirty, timeout_err;
    logic              mem_req, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 0;
    logic              mem_ack = 0;

    eeprom_ram_arbiter #(
        .MEM_AW    (MEM_AW),
        .ADDR_BASE (ADDR_BASE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .eep_read    (eep_read),
        .eep_write   (eep_write),
        .eep_addr    (eep_addr),
        .eep_wdata   (eep_wdata),
        .eep_rdata   (eep_rdata),
        .eep_done    (eep_done),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_ack    (host_ack),
        .dirty_clr   (dirty_clr),
        .dirty       (dirty),
        .timeout_err (timeout_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Backing memory seen by the responder, and the model's view of the image.
    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    bit         m_dirty, m_terr;

    // Memory responder state
    bit                auto_ack = 1;
    int                ack_lat  = 1;
    int                rcnt     = 0;
    logic [MEM_AW-1:0] rec_addr;
    logic              rec_we;
    logic [7:0]        rec_wdata;
    bit                hold_bad;

    typedef struct {
        bit         is_host;
        bit         we;
        bit         both;
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
        int         clr_at;
        logic [7:0] exp_rd;
        bit         chk_rd;
        bit         exp_dirty;
        bit         exp_terr;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Acks mem_req after ack_lat negedges; records the request and flags any change while held.
    initial begin
        logic [MEM_AW-1:0] diff;
        forever begin
            @(negedge clk);
            if (auto_ack) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    rcnt    = 0;
                end else if (mem_req) begin
                    if (rcnt == 0) begin
                        rec_addr  = mem_addr;
                        rec_we    = mem_we;
                        rec_wdata = mem_wdata;
                    end else if (mem_addr !== rec_addr || mem_we !== rec_we || mem_wdata !== rec_wdata) begin
                        hold_bad = 1'b1;
                    end
                    rcnt++;
                    if (rcnt == ack_lat) begin
                        diff = mem_addr - ADDR_BASE;
                        if (mem_we) mem[diff[7:0]] = mem_wdata;
                        mem_rdata = mem[diff[7:0]];
                        mem_ack   = 1'b1;
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    // which: 0 eep_done, 1 host_ack, 2 mem_req
    task automatic wait_for(input int which, input int bound, input string nm);
        bit seen = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if ((which == 0 && eep_done) || (which == 1 && host_ack) || (which == 2 && mem_req)) begin
                seen = 1;
                break;
            end
        end
        check({nm, "_wait"}, seen, 1);
    endtask

    task automatic run(input bit is_host, input bit we, input bit both, input logic [7:0] a,
                       input logic [7:0] d, input int lat, input int clr_at, input logic [7:0] exp_rd,
                       input bit chk_rd, input bit exp_dirty, input bit exp_terr, input string nm);
        int n;
        int exp_n;
        exp_n    = ((lat < TIMEOUT) ? lat : TIMEOUT) + 1;
        ack_lat  = lat;
        hold_bad = 0;
        if (is_host) begin
            host_req = 1; host_we = we; host_addr = a; host_wdata = d;
        end else begin
            eep_write = we; eep_read = !we || both; eep_addr = a; eep_wdata = d;
        end
        dirty_clr = (clr_at == 0);
        for (n = 1; n <= exp_n + 4; n++) begin
            @(negedge clk);
            if (is_host ? host_ack : eep_done) break;
            dirty_clr = (clr_at == n);
        end
        dirty_clr = 0;
        check({nm, "_latency"}, n, exp_n);
        check({nm, "_req_low"}, mem_req, 0);
        check({nm, "_dirty"}, dirty, exp_dirty);
        check({nm, "_terr"}, timeout_err, exp_terr);
        check({nm, "_addr"}, rec_addr, ADDR_BASE + MEM_AW'(a));
        check({nm, "_we"}, rec_we, we);
        if (we) check({nm, "_wdata"}, rec_wdata, d);
        check({nm, "_held"}, hold_bad, 0);
        if (is_host) begin
            if (chk_rd) check({nm, "_hrdata"}, host_rdata, exp_rd);
            host_req = 0;
            @(negedge clk);
            check({nm, "_ack_pulse"}, host_ack, 0);
        end else begin
            if (chk_rd) check({nm, "_erdata"}, eep_rdata, exp_rd);
            repeat (2) begin
                @(negedge clk);
                check({nm, "_hold_done"}, eep_done, 1);
                check({nm, "_hold_req"}, mem_req, 0);
                if (chk_rd) check({nm, "_hold_rdata"}, eep_rdata, exp_rd);
            end
            eep_read = 0; eep_write = 0;
            @(negedge clk);
            check({nm, "_done_fall"}, eep_done, 0);
        end
        if (we && lat <= TIMEOUT) shadow[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = ~8'(i);
            shadow[i] = ~8'(i);
        end
        mem[8'h10]    = 8'h5A;
        shadow[8'h10] = 8'h5A;

        //        host we  both addr   data   lat clr exp_rd chk dirty terr
        vt[0]  = '{0,   1, 0,   8'h3C, 8'hA5, 3,  -1, 8'h00, 0,  1,    0};
        vt[1]  = '{0,   0, 0,   8'h3C, 8'h00, 1,  -1, 8'hA5, 1,  1,    0};
        vt[2]  = '{0,   0, 0,   8'h10, 8'h00, 5,  -1, 8'h5A, 1,  1,    0};
        vt[3]  = '{1,   1, 0,   8'h00, 8'h77, 2,  0,  8'h00, 0,  0,    0};
        vt[4]  = '{1,   0, 0,   8'h00, 8'h00, 1,  -1, 8'h77, 1,  0,    0};
        vt[5]  = '{1,   0, 0,   8'h20, 8'h00, 12, -1, 8'hDF, 1,  0,    0};
        vt[6]  = '{0,   0, 0,   8'h20, 8'h00, 20, -1, 8'hFF, 1,  0,    1};
        vt[7]  = '{0,   1, 0,   8'h44, 8'hC6, 3,  3,  8'h00, 0,  1,    1};
        vt[8]  = '{0,   1, 1,   8'h66, 8'h3E, 2,  -1, 8'h00, 0,  1,    1};
        vt[9]  = '{1,   0, 0,   8'h66, 8'h00, 2,  0,  8'h3E, 1,  0,    1};
        vt[10] = '{0,   1, 0,   8'h70, 8'h99, 30, -1, 8'h00, 0,  1,    1};
        vt[11] = '{1,   0, 0,   8'h70, 8'h00, 1,  -1, 8'h8F, 1,  1,    1};
        vt[12] = '{0,   0, 0,   8'h44, 8'h00, 4,  -1, 8'hC6, 1,  1,    1};

        reset = 1;
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_eep_done", eep_done, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_dirty", dirty, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_eep_rdata", eep_rdata, 8'hFF);
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run(vt[i].is_host, vt[i].we, vt[i].both, vt[i].a, vt[i].d, vt[i].lat, vt[i].clr_at,
                vt[i].exp_rd, vt[i].chk_rd, vt[i].exp_dirty, vt[i].exp_terr, $sformatf("vec%0d", i));

        // Timeout with no ack at all, then a stray ack in IDLE.
        auto_ack = 0;
        eep_read = 1; eep_addr = 8'h50;
        for (int n = 1; n <= TIMEOUT + 6; n++) begin
            @(negedge clk);
            if (eep_done) begin
                check("tmo_latency", n, TIMEOUT + 1);
                break;
            end
        end
        check("tmo_done", eep_done, 1);
        check("tmo_rdata", eep_rdata, 8'hFF);
        check("tmo_terr", timeout_err, 1);
        eep_read = 0;
        @(negedge clk);
        check("tmo_done_fall", eep_done, 0);
        mem_rdata = 8'h33; mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        repeat (2) begin
            @(negedge clk);
            check("late_ack_req", mem_req, 0);
            check("late_ack_done", eep_done, 0);
            check("late_ack_hack", host_ack, 0);
            check("late_ack_erd", eep_rdata, 8'hFF);
            check("late_ack_hrd", host_rdata, 8'h8F);
        end
        auto_ack = 1;

        // Reset in the middle of an EEPROM access.
        run(0, 0, 0, 8'h3C, 8'h00, 1, -1, 8'hA5, 1, 1, 1, "pre_rst");
        ack_lat = 50;
        eep_read = 1; eep_addr = 8'h3C;
        wait_for(2, 4, "rst_mid_req");
        #2 reset = 1;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_done", eep_done, 0);
        check("rst_mid_erd", eep_rdata, 8'hFF);
        check("rst_mid_terr", timeout_err, 0);
        check("rst_mid_dirty", dirty, 0);
        @(negedge clk);
        reset = 0; eep_read = 0;
        @(negedge clk);
        check("rst_idle_req", mem_req, 0);
        check("rst_idle_done", eep_done, 0);
        m_dirty = 0;
        m_terr  = 0;

        // Arbitration: EEPROM first out of reset, then host; later host wins a tie.
        ack_lat = 2;
        eep_read = 1; eep_addr = 8'h10;
        host_req = 1; host_we = 0; host_addr = 8'h20;
        wait_for(2, 4, "arb1_req");
        check("arb1_eep_first", mem_addr, ADDR_BASE + 21'h10);
        wait_for(0, 10, "arb1_edone");
        check("arb1_erd", eep_rdata, shadow[8'h10]);
        repeat (2) begin
            @(negedge clk);
            check("arb1_no_host_in_hold", mem_req, 0);
        end
        eep_read = 0;
        @(negedge clk);
        check("arb1_done_fall", eep_done, 0);
        wait_for(2, 4, "arb1_hreq");
        check("arb1_host_second", mem_addr, ADDR_BASE + 21'h20);
        wait_for(1, 10, "arb1_hack");
        check("arb1_hrd", host_rdata, shadow[8'h20]);
        host_req = 0;
        @(negedge clk);
        eep_read = 1; eep_addr = 8'h10;
        wait_for(0, 10, "arb2_edone");
        host_req = 1; host_addr = 8'h30;
        repeat (2) begin
            @(negedge clk);
            check("arb2_no_host_in_hold", mem_req, 0);
        end
        eep_read = 0;
        @(negedge clk);
        check("arb2_done_fall", eep_done, 0);
        eep_read = 1;
        wait_for(2, 4, "arb2_req");
        check("arb2_host_first", mem_addr, ADDR_BASE + 21'h30);
        wait_for(1, 10, "arb2_hack");
        check("arb2_hrd", host_rdata, shadow[8'h30]);
        host_req = 0;
        wait_for(2, 4, "arb2_ereq");
        check("arb2_eep_second", mem_addr, ADDR_BASE + 21'h10);
        wait_for(0, 10, "arb2_edone2");
        eep_read = 0;
        @(negedge clk);

        // Random traffic against the transaction-level model.
        for (int i = 0; i < 60; i++) begin
            bit         h, w, b, acked, clr_hit;
            logic [7:0] a, d, er;
            int         lat, clr_at, en;
            h      = 1'($urandom_range(0, 1));
            w      = 1'($urandom_range(0, 1));
            b      = !h && w && 1'($urandom_range(0, 1));
            a      = 8'($urandom);
            d      = 8'($urandom);
            lat    = $urandom_range(1, TIMEOUT + 4);
            clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : -1;
            acked  = (lat <= TIMEOUT);
            en     = (acked ? lat : TIMEOUT) + 1;
            clr_hit = (clr_at >= 0) && (clr_at < en);
            er     = acked ? shadow[a] : 8'hFF;
            if (!acked) m_terr = 1;
            if (!h && w)     m_dirty = 1;
            else if (clr_hit) m_dirty = 0;
            run(h, w, b, a, d, lat, clr_at, er, !w, m_dirty, m_terr, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
